hc595_receiver: RTL and testbench
=================================

Name: hc595_receiver

Overview:
- Fabric emulation of a 74HC595 serial-in/parallel-out register: the receiving end of the shcp/stcp/ds link our LED/segment drivers produce.
- Samples asynchronous shcp, stcp and ds pins, shifts MSB-first on shcp rising edges and latches a full word on stcp rising edges.
- Presents the word as parallel data with a one-cycle valid strobe. Flags malformed frames.
- Used for board-to-board links and as a loopback checker for the 595 driver path.

Parameters:
- DATA_W, 16, frame width in bits (>=2).
- SYNC_STAGES, 2, synchronizer depth per input pin (>=2).
- TIMEOUT_CYC, 1024, idle sys_clk cycles before an open frame is abandoned (used only with the optional feature).

Ports:
- sys_clk  input  1  system clock, single clock domain.
- sys_rst  input  1  synchronous, active-high reset.
- shcp  input  1  shift clock pin, asynchronous.
- stcp  input  1  storage/latch clock pin, asynchronous.
- ds  input  1  serial data pin, asynchronous.
- data_out  output  DATA_W  last correctly received word.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse on a malformed or abandoned frame.

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst.
- Reset values:
  - data_out=0, data_valid=0, frame_err=0.
  - Shift register=0, bit counter=0, state=IDLE.
  - Synchronizer chains and edge-detect history registers reset to 1, so a pin held high or low through reset produces no edge.
- Synchronization:
  - Each pin passes through SYNC_STAGES flops.
  - Rising edge = last stage 1 AND history register 0. History updates every cycle.
- Input timing rule: shcp and stcp high and low phases must each last >=2 sys_clk periods. Shorter pulses may be missed and are not required to be detected.
- Shift on shcp rising edge:
  - shift_reg <= {shift_reg[DATA_W-2:0], ds_s}, where ds_s comes from the same synchronizer stage as shcp, in the edge cycle.
  - Bit counter increments, saturating at DATA_W+1.
- States, derived from the bit counter:
  - IDLE (cnt=0).
  - SHIFT (1..DATA_W-1).
  - FULL (cnt=DATA_W).
  - OVER (cnt=DATA_W+1). Shifting continues in OVER, so the register holds the last DATA_W bits.
- Latch on stcp rising edge:
  - In FULL: next cycle data_out <= shift_reg and data_valid=1 for exactly one cycle.
  - In IDLE, SHIFT or OVER: frame_err=1 for one cycle and data_out holds.
  - Every stcp edge returns the counter to 0 (IDLE).
  - Shift register is not cleared.
- Simultaneous shcp and stcp edges in one cycle: the shift is applied first. The count and latched word include the new bit.
- Latency: data_valid asserts exactly SYNC_STAGES+1 sys_clk rising edges after the first edge at which stcp is sampled high.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values on the next edge.
- Back-to-back frames: a new frame's first shcp edge may come in the cycle after the stcp edge with no lost bits.

Optional Feature:
- Macro: HC595_RX_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on any shcp or stcp edge and counts while state != IDLE.
  - When it reaches TIMEOUT_CYC, frame_err pulses one cycle, the bit counter returns to 0 and data_out holds.
  - A stcp edge in the same cycle takes priority over the timeout.
- Undefined: no watchdog logic. An open frame waits indefinitely for stcp.

Test Plan:
1. Reset, then 16 shcp pulses carrying 0xA5C3 MSB-first (4 sys_clk per phase), then stcp pulse -> data_out=0xA5C3, data_valid high 1 cycle at SYNC_STAGES+1 edges after stcp high, frame_err=0.
2. 15 bits then stcp -> frame_err 1-cycle pulse, data_valid=0, data_out stays 0xA5C3. Following 16-bit frame 0x00FF -> data_out=0x00FF.
3. 18 bits (1,1 then 0x1234) then stcp -> frame_err pulse, data_out unchanged. Next 16-bit frame 0x1234 -> valid, data_out=0x1234.
4. Two back-to-back frames 0xFFFF then 0x0001, with first shcp immediately after stcp, plus one cycle with shcp and stcp rising together on bit 16 -> two data_valid pulses, data_out 0xFFFF then 0x0001.
5. sys_rst asserted after 8 bits of 0xBEEF -> all outputs 0 next cycle, no valid. Then full frame 0x5A5A -> data_out=0x5A5A.
6. 5 bits then idle for TIMEOUT_CYC cycles -> with HC595_RX_TIMEOUT_EN, frame_err pulse at cycle TIMEOUT_CYC and next frame 0x0F0F is accepted; without the macro, no pulse and the next stcp flags frame_err (cnt>DATA_W).

Source files
------------

// File: rtl/hc595_receiver.sv
// 74HC595-style serial receiver: synchronizes shcp/stcp/ds, shifts MSB-first, latches full words.
// Optional frame watchdog enabled by defining HC595_RX_TIMEOUT_EN.
module hc595_receiver #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              shcp,
    input  logic              stcp,
    input  logic              ds,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

    logic [SYNC_STAGES-1:0] shcp_sync, stcp_sync, ds_sync;
    logic                   shcp_hist, stcp_hist;
    logic                   shcp_rise, stcp_rise, ds_s;

    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    state_t            frame_state;

    // Chains reset high so a pin parked at either level through reset yields no edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            shcp_sync <= '1;
            stcp_sync <= '1;
            ds_sync   <= '1;
            shcp_hist <= 1'b1;
            stcp_hist <= 1'b1;
        end else begin
            shcp_sync <= {shcp_sync[SYNC_STAGES-2:0], shcp};
            stcp_sync <= {stcp_sync[SYNC_STAGES-2:0], stcp};
            ds_sync   <= {ds_sync[SYNC_STAGES-2:0], ds};
            shcp_hist <= shcp_sync[SYNC_STAGES-1];
            stcp_hist <= stcp_sync[SYNC_STAGES-1];
        end
    end

    assign shcp_rise = shcp_sync[SYNC_STAGES-1] & ~shcp_hist;
    assign stcp_rise = stcp_sync[SYNC_STAGES-1] & ~stcp_hist;
    assign ds_s      = ds_sync[SYNC_STAGES-1];

    // Shift is applied before the latch decision so a coincident stcp sees the new bit.
    always_comb begin
        shift_nxt = shift_reg;
        cnt_nxt   = cnt;
        if (shcp_rise) begin
            shift_nxt = {shift_reg[DATA_W-2:0], ds_s};
            if (cnt != CNT_MAX)
                cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        if (cnt_nxt == '0)
            frame_state = IDLE;
        else if (cnt_nxt < CNT_FULL)
            frame_state = SHIFT;
        else if (cnt_nxt == CNT_FULL)
            frame_state = FULL;
        else
            frame_state = OVER;
    end

`ifdef HC595_RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            shift_reg  <= '0;
            cnt        <= '0;
`ifdef HC595_RX_TIMEOUT_EN
            wdog       <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            shift_reg  <= shift_nxt;
            cnt        <= cnt_nxt;
            if (stcp_rise) begin
                cnt <= '0;
                if (frame_state == FULL) begin
                    data_out   <= shift_nxt;
                    data_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
`ifdef HC595_RX_TIMEOUT_EN
            if (shcp_rise || stcp_rise) begin
                wdog <= '0;
            end else if (cnt != '0) begin
                if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                    wdog      <= '0;
                    cnt       <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wdog <= wdog + WD_W'(1);
                end
            end else begin
                wdog <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hc595_receiver.sv
// Directed bench for hc595_receiver: frame-level model checked every cycle plus literal end-of-test checks.
// Watchdog expectations follow HC595_RX_TIMEOUT_EN when defined.
module tb_hc595_receiver;

    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 1024;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              shcp    = 1'b0;
    logic              stcp    = 1'b0;
    logic              ds      = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;

    hc595_receiver #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .shcp       (shcp),
        .stcp       (stcp),
        .ds         (ds),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int valid_seen = 0;
    int err_seen   = 0;
    bit started   = 1'b0;
    bit done      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: pins become visible SYNC_STAGES cycles after sampling; frames are bit queues.
    logic [2:0]        pv [0:SYNC_STAGES];   // {shcp, stcp, ds}, pv[0] = newest sample
    bit                q[$];
    logic [DATA_W-1:0] exp_data  = '0;
    logic              exp_valid = 1'b0;
    logic              exp_err   = 1'b0;
    int                idle_cyc  = 0;

    always @(posedge sys_clk) begin
        logic sh_r, st_r;
        logic [DATA_W-1:0] w;
        cyc++;
        if (sys_rst) begin
            for (int i = 0; i <= SYNC_STAGES; i++) pv[i] = 3'b111;
            q.delete();
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            idle_cyc  = 0;
            started   = 1'b1;
        end else if (started) begin
            sh_r = pv[SYNC_STAGES-1][2] && !pv[SYNC_STAGES][2];
            st_r = pv[SYNC_STAGES-1][1] && !pv[SYNC_STAGES][1];
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (sh_r) begin
                q.push_back(pv[SYNC_STAGES-1][0]);
                idle_cyc = 0;
            end
            if (st_r) begin
                if (q.size() == DATA_W) begin
                    w = '0;
                    foreach (q[i]) w = {w[DATA_W-2:0], q[i]};
                    exp_data  = w;
                    exp_valid = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
                q.delete();
                idle_cyc = 0;
            end
`ifdef HC595_RX_TIMEOUT_EN
            else if (!sh_r && q.size() != 0) begin
                idle_cyc++;
                if (idle_cyc == TIMEOUT_CYC) begin
                    exp_err = 1'b1;
                    q.delete();
                    idle_cyc = 0;
                end
            end
`endif
            for (int i = SYNC_STAGES; i > 0; i--) pv[i] = pv[i-1];
            pv[0] = {shcp, stcp, ds};
        end
    end

    always @(negedge sys_clk) begin
        if (started && !done) begin
            check("data_out", 32'(data_out), 32'(exp_data));
            check("data_valid", 32'(data_valid), 32'(exp_valid));
            check("frame_err", 32'(frame_err), 32'(exp_err));
            if (data_valid) valid_seen++;
            if (frame_err) err_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_bit(input bit b);
        ds = b;
        idle(4);
        shcp = 1'b1;
        idle(4);
        shcp = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] word, input int n);
        logic [31:0] w;
        w = word;
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic latch();
        stcp = 1'b1;
        idle(4);
        stcp = 1'b0;
        idle(4);
    endtask

    int v0, e0;

    initial begin
        int e1, lat;
        bit found;
        idle(3);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset data_valid", 32'(data_valid), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        idle(3);

        // 1: clean frame, with latency measured from first edge sampling stcp high
        v0 = valid_seen; e0 = err_seen;
        send_bits(32'hA5C3, 16);
        stcp = 1'b1;
        e1 = cyc + 1;
        found = 1'b0;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (data_valid && !found) begin
                found = 1'b1;
                lat = cyc - e1;
            end
            if (i == 3) stcp = 1'b0;
        end
        // edge e1 is itself the first of the SYNC_STAGES+1 edges
        check("t1 latency", 32'(lat), 32'(SYNC_STAGES));
        check("t1 data_out", 32'(data_out), 32'hA5C3);
        check("t1 valid pulses", 32'(valid_seen - v0), 32'd1);
        check("t1 err pulses", 32'(err_seen - e0), 32'd0);

        // 2: short frame
        v0 = valid_seen; e0 = err_seen;
        send_bits(32'h1234, 15);
        latch();
        check("t2 short err", 32'(err_seen - e0), 32'd1);
        check("t2 short no valid", 32'(valid_seen - v0), 32'd0);
        check("t2 hold", 32'(data_out), 32'hA5C3);
        send_bits(32'h00FF, 16);
        latch();
        check("t2 data_out", 32'(data_out), 32'h00FF);

        // 3: long frame
        v0 = valid_seen; e0 = err_seen;
        send_bits(32'h3, 2);
        send_bits(32'h1234, 16);
        latch();
        check("t3 long err", 32'(err_seen - e0), 32'd1);
        check("t3 hold", 32'(data_out), 32'h00FF);
        send_bits(32'h1234, 16);
        latch();
        check("t3 data_out", 32'(data_out), 32'h1234);
        check("t3 valid pulses", 32'(valid_seen - v0), 32'd1);

        // 4: back-to-back frames, second ends with coincident shcp/stcp
        v0 = valid_seen; e0 = err_seen;
        send_bits(32'hFFFF, 16);
        stcp = 1'b1;
        ds   = 1'b0;
        @(negedge sys_clk);
        shcp = 1'b1;
        idle(3);
        stcp = 1'b0;
        @(negedge sys_clk);
        shcp = 1'b0;
        idle(2);
        check("t4 first word", 32'(data_out), 32'hFFFF);
        send_bits(32'h0000, 14);
        ds = 1'b1;
        idle(4);
        shcp = 1'b1;
        stcp = 1'b1;
        idle(4);
        shcp = 1'b0;
        stcp = 1'b0;
        idle(4);
        check("t4 second word", 32'(data_out), 32'h0001);
        check("t4 valid pulses", 32'(valid_seen - v0), 32'd2);
        check("t4 err pulses", 32'(err_seen - e0), 32'd0);

        // 5: reset mid-frame
        send_bits(32'hBE, 8);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t5 rst data_out", 32'(data_out), 32'h0);
        check("t5 rst valid", 32'(data_valid), 32'h0);
        check("t5 rst err", 32'(frame_err), 32'h0);
        sys_rst = 1'b0;
        idle(4);
        v0 = valid_seen;
        send_bits(32'h5A5A, 16);
        latch();
        check("t5 data_out", 32'(data_out), 32'h5A5A);
        check("t5 valid pulses", 32'(valid_seen - v0), 32'd1);

        // 6: abandoned frame
        v0 = valid_seen; e0 = err_seen;
        send_bits(32'h15, 5);
        idle(TIMEOUT_CYC + 20);
`ifdef HC595_RX_TIMEOUT_EN
        check("t6 timeout err", 32'(err_seen - e0), 32'd1);
`else
        check("t6 no timeout", 32'(err_seen - e0), 32'd0);
        send_bits(32'h0F0F, 16);
        latch();
        check("t6 overlong err", 32'(err_seen - e0), 32'd1);
        check("t6 hold", 32'(data_out), 32'h5A5A);
`endif
        send_bits(32'h0F0F, 16);
        latch();
        check("t6 data_out", 32'(data_out), 32'h0F0F);
        check("t6 valid pulses", 32'(valid_seen - v0), 32'd1);

        idle(2);
        done = 1'b1;
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
